rmt_ctrl_pkt_gen: RTL and testbench

RMT_CTRL_PKT_GEN -- requirements
Module: rmt_ctrl_pkt_gen

---
 rtl/rmt_ctrl_pkt_gen.sv | 199 +++++++++++++++++++
 tb/tb_rmt_ctrl_pkt_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rmt_ctrl_pkt_gen.sv
// Control-packet generator: turns one table-write request into a 2-beat Ethernet/VLAN/IPv4/UDP packet on a 512-bit AXI-Stream.
// Optional macro RMT_CTRL_IP_CSUM_EN adds a CSUM state that fills in the IPv4 header checksum.
module rmt_ctrl_pkt_gen #(
    parameter int          C_M_AXIS_DATA_WIDTH  = 512,
    parameter int          C_M_AXIS_TUSER_WIDTH = 128,
    parameter logic [15:0] CTRL_UDP_PORT        = 16'hf1f2,
    parameter logic [11:0] CTRL_VLAN_ID         = 12'h00f,
    parameter logic [31:0] SRC_IP               = 32'h01000000,
    parameter logic [31:0] DST_IP               = 32'hdededede
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cfg_valid,
    output logic                                 cfg_ready,
    input  logic [7:0]                           cfg_resource_id,
    input  logic [7:0]                           cfg_index,
    input  logic [5:0]                           cfg_len,
    input  logic [255:0]                         cfg_payload,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                                 m_axis_tvalid,
    output logic                                 m_axis_tlast,
    input  logic                                 m_axis_tready,
    output logic                                 err_len
);
    localparam int KEEP_W = C_M_AXIS_DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, CSUM, HDR, PAY} state_t;

    state_t         state_reg, state_next;
    logic [7:0]     id_reg, idx_reg, seq_reg;
    logic [5:0]     len_reg;
    logic [255:0]   payload_reg;
    logic           err_len_reg;
    logic           accept, len_legal;
    logic [15:0]    ip_len, udp_len, pkt_len, csum_field;
    logic [7:0]     hdr_byte [64];
    logic [511:0]   hdr_flat;
    logic [255:0]   pay_flat;
    logic [63:0]    keep_mask;

    assign cfg_ready = (state_reg == IDLE) && !rst;
    assign accept    = cfg_valid && cfg_ready;
    assign len_legal = (cfg_len != 6'd0) && (cfg_len <= 6'd32);
    assign err_len   = err_len_reg;

    assign ip_len  = 16'd46 + {10'd0, len_reg};
    assign udp_len = 16'd26 + {10'd0, len_reg};
    assign pkt_len = 16'd64 + {10'd0, len_reg};

`ifdef RMT_CTRL_IP_CSUM_EN
    logic [15:0] csum_reg;
    logic [19:0] csum_sum;
    logic [16:0] csum_fold1;
    logic [16:0] csum_fold2;

    // Only total length varies per packet; all other header words are constants.
    assign csum_sum   = 20'h04500 + {4'd0, ip_len} + 20'h04011
                      + {4'd0, SRC_IP[31:16]} + {4'd0, SRC_IP[15:0]}
                      + {4'd0, DST_IP[31:16]} + {4'd0, DST_IP[15:0]};
    assign csum_fold1 = {1'b0, csum_sum[15:0]} + {13'd0, csum_sum[19:16]};
    assign csum_fold2 = {1'b0, csum_fold1[15:0]} + {16'd0, csum_fold1[16]};
    assign csum_field = ~csum_fold2[15:0];
`else
    assign csum_field = 16'h0000;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            id_reg      <= '0;
            idx_reg     <= '0;
            len_reg     <= '0;
            payload_reg <= '0;
            seq_reg     <= '0;
            err_len_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            err_len_reg <= accept && !len_legal;
            if (accept && len_legal) begin
                id_reg      <= cfg_resource_id;
                idx_reg     <= cfg_index;
                len_reg     <= cfg_len;
                payload_reg <= cfg_payload;
            end
            if (state_reg == PAY && m_axis_tready)
                seq_reg <= seq_reg + 8'd1;
        end
    end

`ifdef RMT_CTRL_IP_CSUM_EN
    always_ff @(posedge clk) begin
        if (rst)
            csum_reg <= '0;
        else if (state_reg == CSUM)
            csum_reg <= csum_field;
    end
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept && len_legal) begin
`ifdef RMT_CTRL_IP_CSUM_EN
                    state_next = CSUM;
`else
                    state_next = HDR;
`endif
                end
            end
            CSUM:    state_next = HDR;
            HDR:     if (m_axis_tready) state_next = PAY;
            PAY:     if (m_axis_tready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        for (int n = 0; n < 64; n++)
            hdr_byte[n] = 8'h00;
        for (int n = 0; n < 6; n++) begin
            hdr_byte[n]     = 8'(8'h06 + n);
            hdr_byte[6 + n] = 8'(n);
        end
        hdr_byte[12] = 8'h81;
        hdr_byte[14] = {4'h0, CTRL_VLAN_ID[11:8]};
        hdr_byte[15] = CTRL_VLAN_ID[7:0];
        hdr_byte[16] = 8'h08;
        hdr_byte[18] = 8'h45;
        hdr_byte[20] = ip_len[15:8];
        hdr_byte[21] = ip_len[7:0];
        hdr_byte[26] = 8'h40;
        hdr_byte[27] = 8'h11;
`ifdef RMT_CTRL_IP_CSUM_EN
        hdr_byte[28] = csum_reg[15:8];
        hdr_byte[29] = csum_reg[7:0];
`else
        hdr_byte[28] = csum_field[15:8];
        hdr_byte[29] = csum_field[7:0];
`endif
        hdr_byte[30] = SRC_IP[31:24];
        hdr_byte[31] = SRC_IP[23:16];
        hdr_byte[32] = SRC_IP[15:8];
        hdr_byte[33] = SRC_IP[7:0];
        hdr_byte[34] = DST_IP[31:24];
        hdr_byte[35] = DST_IP[23:16];
        hdr_byte[36] = DST_IP[15:8];
        hdr_byte[37] = DST_IP[7:0];
        hdr_byte[38] = 8'h04;
        hdr_byte[39] = 8'hd2;
        hdr_byte[40] = CTRL_UDP_PORT[15:8];
        hdr_byte[41] = CTRL_UDP_PORT[7:0];
        hdr_byte[42] = udp_len[15:8];
        hdr_byte[43] = udp_len[7:0];
        hdr_byte[46] = id_reg;
        hdr_byte[47] = seq_reg;
        hdr_byte[48] = idx_reg;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_hdr_pack
            assign hdr_flat[8*gi +: 8] = hdr_byte[gi];
        end
        // Bytes past the request length go out as zero, not stale payload.
        for (gi = 0; gi < 32; gi++) begin : g_pay_mask
            assign pay_flat[8*gi +: 8] = (len_reg > 6'(gi)) ? payload_reg[8*gi +: 8] : 8'h00;
        end
    endgenerate

    assign keep_mask = (64'd1 << len_reg) - 64'd1;

    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        case (state_reg)
            HDR: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_flat[C_M_AXIS_DATA_WIDTH-1:0];
                m_axis_tkeep  = '1;
                m_axis_tuser  = {{(C_M_AXIS_TUSER_WIDTH-16){1'b0}}, pkt_len};
            end
            PAY: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tdata  = {{(C_M_AXIS_DATA_WIDTH-256){1'b0}}, pay_flat};
                m_axis_tkeep  = keep_mask[KEEP_W-1:0];
                m_axis_tuser  = {{(C_M_AXIS_TUSER_WIDTH-16){1'b0}}, pkt_len};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rmt_ctrl_pkt_gen.sv
// Randomized directed bench for rmt_ctrl_pkt_gen: a byte-level packet model predicts every beat.
// Honors RMT_CTRL_IP_CSUM_EN when defined for the build.
module tb_rmt_ctrl_pkt_gen;
    localparam logic [15:0] PORT = 16'hf1f2;
    localparam logic [11:0] VID  = 12'h00f;
    localparam logic [31:0] SIP  = 32'h01000000;
    localparam logic [31:0] DIP  = 32'hdededede;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [7:0]   cfg_resource_id;
    logic [7:0]   cfg_index;
    logic [5:0]   cfg_len;
    logic [255:0] cfg_payload;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready;
    logic         err_len;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_seq = 8'd0;

    always #5 clk = ~clk;

    rmt_ctrl_pkt_gen #(
        .C_M_AXIS_DATA_WIDTH (512),
        .C_M_AXIS_TUSER_WIDTH(128),
        .CTRL_UDP_PORT       (PORT),
        .CTRL_VLAN_ID        (VID),
        .SRC_IP              (SIP),
        .DST_IP              (DIP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_resource_id(cfg_resource_id),
        .cfg_index      (cfg_index),
        .cfg_len        (cfg_len),
        .cfg_payload    (cfg_payload),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .err_len        (err_len)
    );

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Header as a list of wire bytes, filled field by field from the packet format.
    function automatic logic [511:0] model_beat0(input logic [7:0] id, input logic [7:0] idx,
                                                 input int len, input logic [7:0] seq);
        logic [7:0]   b [64];
        logic [511:0] d;
        int ip_len  = 46 + len;
        int udp_len = 26 + len;
        for (int n = 0; n < 64; n++) b[n] = 8'h00;
        for (int n = 0; n < 6; n++) begin
            b[n]     = 8'(6 + n);
            b[6 + n] = 8'(n);
        end
        b[12] = 8'h81; b[13] = 8'h00;
        b[14] = 8'(VID >> 8); b[15] = 8'(VID);
        b[16] = 8'h08; b[17] = 8'h00;
        b[18] = 8'h45;
        b[20] = 8'(ip_len >> 8); b[21] = 8'(ip_len);
        b[26] = 8'h40; b[27] = 8'h11;
        for (int n = 0; n < 4; n++) begin
            b[30 + n] = 8'(SIP >> (24 - 8 * n));
            b[34 + n] = 8'(DIP >> (24 - 8 * n));
        end
        b[38] = 8'h04; b[39] = 8'hd2;
        b[40] = 8'(PORT >> 8); b[41] = 8'(PORT);
        b[42] = 8'(udp_len >> 8); b[43] = 8'(udp_len);
        b[46] = id; b[47] = seq; b[48] = idx;
`ifdef RMT_CTRL_IP_CSUM_EN
        begin
            int s = 0;
            for (int w = 0; w < 10; w++) s += {b[18 + 2 * w], b[19 + 2 * w]};
            while (s > 32'hffff) s = (s & 32'hffff) + (s >> 16);
            s = ~s & 32'hffff;
            b[28] = 8'(s >> 8); b[29] = 8'(s);
        end
`endif
        for (int n = 0; n < 64; n++) d[8 * n +: 8] = b[n];
        return d;
    endfunction

    function automatic logic [511:0] model_beat1(input logic [255:0] pay, input int len);
        logic [511:0] d = '0;
        for (int n = 0; n < len; n++) d[8 * n +: 8] = pay[8 * n +: 8];
        return d;
    endfunction

    function automatic logic [63:0] model_keep1(input int len);
        logic [63:0] k = '0;
        for (int n = 0; n < len; n++) k[n] = 1'b1;
        return k;
    endfunction

    // mode 0: always ready, 1: 10-cycle stall then toggle, 2: random; abort resets during a PAY stall.
    task automatic run_pkt(input logic [7:0] id, input logic [7:0] idx, input int len,
                           input int mode, input bit abort);
        logic [255:0] pay;
        logic [511:0] e0, e1, ed;
        logic [63:0]  k1, ek;
        int beat, cyc;
        for (int w = 0; w < 8; w++) pay[32 * w +: 32] = $urandom;
        e0 = model_beat0(id, idx, len, exp_seq);
        e1 = model_beat1(pay, len);
        k1 = model_keep1(len);
        cfg_valid = 1'b1; cfg_resource_id = id; cfg_index = idx;
        cfg_len = 6'(len); cfg_payload = pay; m_axis_tready = 1'b0;
        chk("ready_idle", 512'(cfg_ready), 512'(1'b1));
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        cfg_resource_id = 8'($urandom); cfg_index = 8'($urandom); cfg_len = 6'($urandom);
        for (int w = 0; w < 8; w++) cfg_payload[32 * w +: 32] = $urandom;
`ifdef RMT_CTRL_IP_CSUM_EN
        @(negedge clk);
        chk("csum_gap_tvalid", 512'(m_axis_tvalid), 512'(1'b0));
`endif
        beat = 0; cyc = 0;
        while (beat < 2) begin
            @(negedge clk);
            cyc++;
            ed = (beat == 0) ? e0 : e1;
            ek = (beat == 0) ? 64'hffff_ffff_ffff_ffff : k1;
            chk("tvalid", 512'(m_axis_tvalid), 512'(1'b1));
            chk("tlast", 512'(m_axis_tlast), 512'(beat == 1));
            chk("tdata", m_axis_tdata, ed);
            chk("tkeep", 512'(m_axis_tkeep), 512'(ek));
            chk("tuser", 512'(m_axis_tuser), 512'(16'(64 + len)));
            chk("ready_busy", 512'(cfg_ready), 512'(1'b0));
`ifdef RMT_CTRL_IP_CSUM_EN
            if (beat == 0 && cyc == 1) begin
                int s = 0;
                for (int w = 0; w < 10; w++) s += m_axis_tdata[8 * (18 + 2 * w) +: 8] * 256
                                                + m_axis_tdata[8 * (19 + 2 * w) +: 8];
                while (s > 32'hffff) s = (s & 32'hffff) + (s >> 16);
                chk("ip_csum_verify", 512'(s), 512'(32'hffff));
            end
`endif
            if (abort && beat == 1 && cyc == 3) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                chk("abort_tvalid", 512'(m_axis_tvalid), 512'(1'b0));
                chk("abort_tlast", 512'(m_axis_tlast), 512'(1'b0));
                chk("abort_ready_in_rst", 512'(cfg_ready), 512'(1'b0));
                rst = 1'b0;
                #1;
                chk("abort_ready_after", 512'(cfg_ready), 512'(1'b1));
                exp_seq = 8'd0;
                $display("pkt id=%02h idx=%02h len=%0d aborted", id, idx, len);
                return;
            end
            if (abort && beat == 1)      m_axis_tready = 1'b0;
            else if (mode == 1)          m_axis_tready = (cyc > 10) && (cyc % 2 == 0);
            else if (mode == 2)          m_axis_tready = (cyc > 20) ? 1'b1 : 1'($urandom_range(0, 1));
            else                         m_axis_tready = 1'b1;
            @(posedge clk);
            if (m_axis_tready) begin
                beat++;
                cyc = 0;
            end
        end
        #1 m_axis_tready = 1'b0;
        @(negedge clk);
        chk("post_tvalid", 512'(m_axis_tvalid), 512'(1'b0));
        chk("post_ready", 512'(cfg_ready), 512'(1'b1));
        $display("pkt id=%02h idx=%02h len=%0d seq=%0d mode=%0d", id, idx, len, exp_seq, mode);
        exp_seq = exp_seq + 8'd1;
    endtask

    task automatic bad_len(input int len);
        cfg_valid = 1'b1; cfg_len = 6'(len);
        cfg_resource_id = 8'($urandom); cfg_index = 8'($urandom);
        chk("bad_ready", 512'(cfg_ready), 512'(1'b1));
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("err_len_pulse", 512'(err_len), 512'(1'b1));
        chk("bad_tvalid0", 512'(m_axis_tvalid), 512'(1'b0));
        @(negedge clk);
        chk("err_len_clear", 512'(err_len), 512'(1'b0));
        chk("bad_tvalid1", 512'(m_axis_tvalid), 512'(1'b0));
        chk("bad_ready_after", 512'(cfg_ready), 512'(1'b1));
        $display("bad len=%0d", len);
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; m_axis_tready = 1'b0;
        cfg_resource_id = '0; cfg_index = '0; cfg_len = '0; cfg_payload = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 512'(cfg_ready), 512'(1'b0));
        chk("rst_tvalid", 512'(m_axis_tvalid), 512'(1'b0));
        chk("rst_tlast", 512'(m_axis_tlast), 512'(1'b0));
        chk("rst_tdata", m_axis_tdata, 512'(0));
        chk("rst_tkeep", 512'(m_axis_tkeep), 512'(0));
        chk("rst_tuser", 512'(m_axis_tuser), 512'(0));
        chk("rst_err", 512'(err_len), 512'(1'b0));
        rst = 1'b0;
        #1;
        chk("rst_ready_after", 512'(cfg_ready), 512'(1'b1));

        run_pkt(8'h01, 8'h00, 20, 0, 1'b0);
        run_pkt(8'($urandom), 8'($urandom), 1, 0, 1'b0);
        run_pkt(8'($urandom), 8'($urandom), 32, 0, 1'b0);
        run_pkt(8'($urandom), 8'($urandom), $urandom_range(1, 32), 1, 1'b0);
        bad_len(0);
        bad_len(33);
        bad_len($urandom_range(34, 63));
        run_pkt(8'($urandom), 8'($urandom), $urandom_range(1, 32), 2, 1'b0);
        for (int i = 0; i < 258; i++)
            run_pkt(8'($urandom), 8'($urandom), $urandom_range(1, 32), (i % 16 == 0) ? 2 : 0, 1'b0);
        run_pkt(8'($urandom), 8'($urandom), $urandom_range(1, 32), 0, 1'b1);
        run_pkt(8'($urandom), 8'($urandom), $urandom_range(1, 32), 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
